// File: rtl/mac_accum.sv
// ---------------------------------------------------------------------------
// mac_accum
//
// Dot-product accumulator stage that feeds the ReLU activation stage.
// One operation computes a single neuron output:
//
//   data_out = sat16( round( (bias << FRAC_BITS) + sum(data[i] * weight[i]) ) )
//
// for VEC_LEN element pairs, all in signed Q8.8. Products are kept at full
// Q16.16 precision in a wide accumulator. The result is rounded half toward
// +inf back to Q8.8 and saturated to 16 bits only at the output. The result
// appears with a single-cycle valid pulse.
//
// Parameters
//   VEC_LEN    number of products per output (1..255)
//   ACC_WIDTH  accumulator width, >= 32 + ceil(log2(VEC_LEN+1))
//   FRAC_BITS  fractional bits of the Q format (products carry 2*FRAC_BITS)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse beginning an operation (honoured only in IDLE)
//   bias_in    signed Q8.8 bias, sampled on the accepted start cycle
//   valid_in   data_in/weight_in carry one element this cycle
//   data_in    signed Q8.8 activation
//   weight_in  signed Q8.8 weight
//   data_out   signed Q8.8 result, held between results
//   valid_out  one-cycle pulse marking data_out as new
//   busy       high whenever the stage is not IDLE
// ---------------------------------------------------------------------------
module mac_accum #(
  parameter int VEC_LEN   = 9,
  parameter int ACC_WIDTH = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias_in,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  input  logic [15:0] weight_in,
  output logic [15:0] data_out,
  output logic        valid_out,
  output logic        busy
);

  // The element counter must reach VEC_LEN-1, and VEC_LEN is at most 255.
  localparam int CntW = 8;
  localparam logic [CntW-1:0] LastIdx = CntW'(VEC_LEN - 1);

  // Adding half an output LSB before the arithmetic shift turns the floor
  // of the shift into round-half-toward-plus-infinity.
  localparam logic [ACC_WIDTH-1:0] RoundConst =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  // Saturation limits of the 16-bit output, in accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] MaxOut = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] MinOut = ACC_WIDTH'(-32768);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e                        state_q,    state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q,      acc_d;
  logic        [CntW-1:0]        cnt_q,      cnt_d;
  logic        [15:0]            data_out_q, data_out_d;
  logic                          valid_out_q, valid_out_d;

  logic signed [31:0]            prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   rounded;
  logic        [15:0]            clamped;

  // Full-precision Q16.16 product. Both operands are signed, so the 32-bit
  // result is exact, including -32768 * -32768.
  always_comb begin
    prod     = $signed(data_in) * $signed(weight_in);
    prod_ext = {{(ACC_WIDTH-32){prod[31]}}, prod};
  end

  // The bias is aligned to the product's binary point (Q8.8 -> Q16.16).
  always_comb begin
    bias_ext = {{(ACC_WIDTH-16-FRAC_BITS){bias_in[15]}}, bias_in,
                {FRAC_BITS{1'b0}}};
  end

  // Round back to Q8.8, then clamp into the signed 16-bit range. The
  // accumulator is wide enough that the rounding add cannot wrap.
  always_comb begin
    rounded = $signed(acc_q + RoundConst) >>> FRAC_BITS;
    if (rounded > MaxOut) begin
      clamped = 16'h7FFF;
    end else if (rounded < MinOut) begin
      clamped = 16'h8000;
    end else begin
      clamped = rounded[15:0];
    end
  end

  // Next-state logic. Element inputs are only looked at in ACCUM and start
  // only in IDLE, so stray pulses elsewhere fall through to the defaults.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (valid_in) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastIdx) begin
            state_d = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        data_out_d  = clamped;
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. The reset discards any partial operation without a
  // valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_mac_accum
//
// Directed self-checking bench for mac_accum with the default parameters
// (VEC_LEN = 9). A table of single-operation vectors is applied in a loop.
// Hand-written sequences then cover gaps and ignored inputs, back-to-back
// operations and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_mac_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bias_in;
  logic        valid_in;
  logic [15:0] data_in;
  logic [15:0] weight_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] bias;
    logic [15:0] data;
    logic [15:0] weight;
    logic [15:0] expected;
    bit          checkRelu;
  } vec_t;

  vec_t vecs[6];

  mac_accum #(
    .VEC_LEN  (9),
    .ACC_WIDTH(40),
    .FRAC_BITS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias_in  (bias_in),
    .valid_in (valid_in),
    .data_in  (data_in),
    .weight_in(weight_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .busy     (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with the expected value.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual,
               expected);
    end
  endtask

  // Behavioural ReLU of the downstream stage.
  function automatic logic [15:0] relu(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  // Pulse start with the given bias for one cycle.
  task automatic startOp(input logic [15:0] bias);
    start   = 1'b1;
    bias_in = bias;
    tick();
    start   = 1'b0;
    checkOutput("busy after start", {15'd0, busy}, 16'd1);
  endtask

  // Feed n identical elements, optionally with an idle cycle after each.
  task automatic feed(input logic [15:0] d, input logic [15:0] w,
                      input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      valid_in  = 1'b1;
      data_in   = d;
      weight_in = w;
      tick();
      valid_in  = 1'b0;
      if (gap && i != n - 1) begin
        tick();
      end
    end
  endtask

  // Called right after the last element edge k: checks the pulse at k+1
  // and its fall at k+2.
  task automatic finishCheck(input string name, input logic [15:0] expected);
    checkOutput({name, " no valid at k"}, {15'd0, valid_out}, 16'd0);
    checkOutput({name, " busy at k"}, {15'd0, busy}, 16'd1);
    tick();
    checkOutput({name, " valid at k+1"}, {15'd0, valid_out}, 16'd1);
    checkOutput({name, " data_out"}, data_out, expected);
    checkOutput({name, " idle at k+1"}, {15'd0, busy}, 16'd0);
    tick();
    checkOutput({name, " valid falls k+2"}, {15'd0, valid_out}, 16'd0);
    checkOutput({name, " data held"}, data_out, expected);
  endtask

  // One complete operation from a table vector.
  task automatic applyStimulus(input vec_t v);
    startOp(v.bias);
    feed(v.data, v.weight, 9, 1'b0);
    finishCheck(v.name, v.expected);
    if (v.checkRelu) begin
      checkOutput({v.name, " relu"}, relu(data_out), 16'h0000);
    end
  endtask

  initial begin
    // Expected values:
    //   unity:  9 * 1.0 * 1.0                     = 9.0   -> 0x0900
    //   negb:   0.5 + 9 * (1.0 * -1.0)            = -8.5  -> 0xF780
    //   rnd+:   9 * 128 = 1152 (4.5 LSB), rounds up        -> 0x0005
    //   rnd-:   -1152 (-4.5 LSB), half toward +inf         -> 0xFFFC
    //   sat+:   9 * 0x7FFF^2 overflows high                -> 0x7FFF
    //   sat-:   9 * (-32768 * 32767) overflows low         -> 0x8000
    vecs[0] = '{"unity", 16'h0000, 16'h0100, 16'h0100, 16'h0900, 1'b0};
    vecs[1] = '{"negb",  16'h0080, 16'h0100, 16'hFF00, 16'hF780, 1'b1};
    vecs[2] = '{"rnd+",  16'h0000, 16'h0001, 16'h0080, 16'h0005, 1'b0};
    vecs[3] = '{"rnd-",  16'h0000, 16'h0001, 16'hFF80, 16'hFFFC, 1'b0};
    vecs[4] = '{"sat+",  16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[5] = '{"sat-",  16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    bias_in   = '0;
    valid_in  = 1'b0;
    data_in   = '0;
    weight_in = '0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset data_out", data_out, 16'h0000);
    checkOutput("reset valid_out", {15'd0, valid_out}, 16'd0);
    checkOutput("reset busy", {15'd0, busy}, 16'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Ignored inputs and gaps. valid_in in IDLE must not start or count,
    // valid_in in the start cycle is ignored, a start mid-ACCUM is ignored,
    // and valid_in during OUTPUT is ignored.
    valid_in  = 1'b1;
    data_in   = 16'h7FFF;
    weight_in = 16'h7FFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle valid_in busy", {15'd0, busy}, 16'd0);
      checkOutput("idle valid_in vout", {15'd0, valid_out}, 16'd0);
    end
    startOp(16'h0000);
    valid_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid_in  = 1'b1;
      data_in   = 16'h0100;
      weight_in = 16'h0100;
      if (i == 4) begin
        start   = 1'b1;
        bias_in = 16'h7F00;
      end
      tick();
      start    = 1'b0;
      valid_in = 1'b0;
      if (i != 8) begin
        checkOutput("gap busy after elem", {15'd0, busy}, 16'd1);
        data_in   = 16'h7FFF;
        weight_in = 16'h7FFF;
        tick();
        checkOutput("gap busy in gap", {15'd0, busy}, 16'd1);
        checkOutput("gap no early valid", {15'd0, valid_out}, 16'd0);
      end
    end
    valid_in  = 1'b1;
    data_in   = 16'h7FFF;
    weight_in = 16'h7FFF;
    finishCheck("gaps", 16'h0900);
    valid_in = 1'b0;

    // Back-to-back: a new start is accepted in the valid_out cycle.
    startOp(16'h0000);
    feed(16'h0100, 16'h0100, 9, 1'b0);
    checkOutput("b2b first no valid", {15'd0, valid_out}, 16'd0);
    tick();
    checkOutput("b2b first valid", {15'd0, valid_out}, 16'd1);
    checkOutput("b2b first data", data_out, 16'h0900);
    startOp(16'h0000);
    checkOutput("b2b single pulse", {15'd0, valid_out}, 16'd0);
    checkOutput("b2b data held", data_out, 16'h0900);
    feed(16'h0001, 16'h0080, 9, 1'b0);
    finishCheck("b2b second", 16'h0005);

    // Reset after four elements discards the operation.
    startOp(16'h0000);
    feed(16'h0100, 16'h0100, 4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst data_out", data_out, 16'h0000);
    checkOutput("midrst valid_out", {15'd0, valid_out}, 16'd0);
    checkOutput("midrst busy", {15'd0, busy}, 16'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 14; i++) begin
        tick();
        if (valid_out) pulses++;
      end
      checkOutput("midrst no valid", 16'(pulses), 16'd0);
    end
    applyStimulus(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
# mac_accum

Dot-product accumulator stage that feeds the ReLU activation stage in the DNN datapath. It computes one neuron output per operation: a Q8.8 bias plus VEC_LEN products of Q8.8 activations and weights, accumulated at full precision. The result is rounded back to Q8.8 and saturated to 16 bits. It is emitted as a single-cycle valid pulse whose data/valid pair connects directly to the activation stage's valid_in/data_in.

## Interface
- VEC_LEN, 9: number of products per output (3x3 kernel); legal range 1..255.
- ACC_WIDTH, 40: accumulator width in bits; must be at least 32 + ceil(log2(VEC_LEN+1)).
- FRAC_BITS, 8: fractional bits of the Q format; products carry 2*FRAC_BITS.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins an operation; honoured only in IDLE.
- bias_in  input  16  signed Q8.8 bias, sampled on the accepted start cycle.
- valid_in  input  1  data_in/weight_in carry one element this cycle.
- data_in  input  16  signed Q8.8 activation.
- weight_in  input  16  signed Q8.8 weight.
- data_out  output  16  signed Q8.8 result; holds its value between results.
- valid_out  output  1  one-cycle pulse marking data_out as new.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCUM, OUTPUT. busy = (state != IDLE).
- IDLE + start: acc <= sign-extend(bias_in) << FRAC_BITS, cnt <= 0, state <= ACCUM. valid_in in the same cycle is ignored.
- ACCUM + valid_in: acc <= acc + sign-extend(data_in * weight_in), where the product is a 32-bit signed value; cnt <= cnt + 1. If cnt == VEC_LEN-1, state <= OUTPUT.
- ACCUM without valid_in: acc and cnt hold. Gaps of any length are allowed; there is no timeout.
- OUTPUT: r = (acc + (1 << (FRAC_BITS-1))) >>> FRAC_BITS, an arithmetic shift that rounds half toward +inf.
  - data_out <= clamp(r, -32768, 32767); valid_out <= 1; state <= IDLE.
- start outside IDLE is ignored. valid_in in IDLE or OUTPUT is ignored and is neither counted nor accumulated.
- The accumulator never wraps for legal parameters. Saturation is applied only at output, never on intermediate sums.
- Reset at any time, including mid-ACCUM: state <= IDLE, acc <= 0, cnt <= 0, data_out <= 0, valid_out <= 0. The partial operation is discarded and no valid_out is produced for it.

## Timing
- Reset values: data_out = 0, valid_out = 0, busy = 0.
- start accepted at edge t: busy is high from after t. The first element can be accepted at edge t+1.
- Last element accepted at edge k: state becomes OUTPUT after k. data_out and valid_out update at edge k+1. valid_out falls at edge k+2, and busy falls after edge k+1.
- Minimum operation is VEC_LEN + 2 cycles from start to valid_out. The next start can be accepted in the cycle that valid_out is high.
- valid_out is never high for two consecutive cycles.
- There is no backpressure, because the downstream activation stage accepts every valid cycle.

## Test plan
- Unity: bias 0x0000; 9 elements of data 0x0100 and weight 0x0100 -> data_out 0x0900, valid_out high for exactly 1 cycle, at edge k+1.
- Negative plus bias: bias 0x0080; 9 elements of data 0x0100 and weight 0xFF00 -> data_out 0xF780 (-8.5). Pass this value through ReLU and check that it gives 0.
- Rounding: bias 0; 9 elements of data 0x0001 and weight 0x0080 (sum 0x480 = 4.5 LSB) -> data_out 0x0005. Repeat with weight 0xFF80 (-4.5 LSB) -> data_out 0xFFFC.
- Saturation: 9 elements of data 0x7FFF and weight 0x7FFF -> 0x7FFF. 9 elements of data 0x8000 and weight 0x7FFF -> 0x8000.
- Gaps and ignored inputs: apply valid_in on alternate cycles; pulse start mid-ACCUM; drive valid_in in IDLE -> the unity case still gives 0x0900 after exactly 9 accepted elements, and busy is high throughout.
- Reset mid-operation: assert rst after 4 elements -> outputs are 0 and no valid_out follows. A fresh unity operation then yields 0x0900.
